// File: rtl/expr_eval_ctrl_pkg.sv
// Shared constants for the expression evaluator: character codes and the
// one-hot FSM state encoding.
package expr_pkg;

  localparam logic [7:0] CH_0   = 8'd48;
  localparam logic [7:0] CH_9   = 8'd57;
  localparam logic [7:0] CH_MUL = 8'd42;
  localparam logic [7:0] CH_ADD = 8'd43;
  localparam logic [7:0] CH_EQ  = 8'd61;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_NUM  = 5'b00010;
  localparam logic [4:0] ST_OP   = 5'b00100;
  localparam logic [4:0] ST_ERR  = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

endpackage

// File: rtl/expr_eval_ctrl_if.sv
// Character input channel and result output channel of the evaluator.
// slave is the evaluator side, master is the source/consumer side.
interface expr_eval_ctrl_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_err
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_err
  );

endinterface

// File: rtl/expr_eval_ctrl_char_class.sv
// Combinational classifier for one ASCII character of the expression stream.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_mul,
  output logic       is_eq,
  output logic [3:0] digit
);

  assign is_digit = (in >= CH_0) && (in <= CH_9);
  assign is_mul   = (in == CH_MUL);
  assign is_op    = is_mul || (in == CH_ADD);
  assign is_eq    = (in == CH_EQ);
  // ASCII digits are 0x30..0x39, so the low nibble is already the value.
  assign digit    = is_digit ? in[3:0] : 4'd0;

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for "digit (op digit)* =" with '*' above '+'.
// Holds the sum/product accumulators, the parse FSM and the result register.
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             clr_n,
  expr_eval_ctrl_if.slave bus
);

  logic [4:0]       state_reg, state_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0] res_data_reg, res_data_next;
  logic             res_err_reg, res_err_next;

  logic             is_digit, is_op, is_mul, is_eq;
  logic [3:0]       digit;
  logic             accept;
  logic [WIDTH-1:0] prod_mul;
  logic [WIDTH-1:0] sum_prod;

  expr_char_class u_class (
    .in       (bus.in_data),
    .is_digit (is_digit),
    .is_op    (is_op),
    .is_mul   (is_mul),
    .is_eq    (is_eq),
    .digit    (digit)
  );

  assign bus.in_ready  = (state_reg != ST_DONE);
  assign bus.res_valid = (state_reg == ST_DONE);
  assign bus.res_data  = res_data_reg;
  assign bus.res_err   = res_err_reg;

  assign accept   = bus.in_valid && bus.in_ready;
  assign prod_mul = prod_reg * WIDTH'(digit);
  assign sum_prod = sum_reg + prod_reg;

  always_comb begin
    state_next    = state_reg;
    sum_next      = sum_reg;
    prod_next     = prod_reg;
    res_data_next = res_data_reg;
    res_err_next  = res_err_reg;
    case (state_reg)
      ST_IDLE, ST_OP: begin
        if (accept) begin
          if (is_digit) begin
            state_next = ST_NUM;
            prod_next  = prod_mul;
          end else if (is_eq) begin
            state_next    = ST_DONE;
            res_data_next = '0;
            res_err_next  = 1'b1;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_NUM: begin
        if (accept) begin
          if (is_op) begin
            state_next = ST_OP;
            // '*' keeps extending the current product term; '+' closes it.
            if (!is_mul) begin
              sum_next  = sum_prod;
              prod_next = WIDTH'(1);
            end
          end else if (is_eq) begin
            state_next    = ST_DONE;
            res_data_next = sum_prod;
            res_err_next  = 1'b0;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (accept && is_eq) begin
          state_next    = ST_DONE;
          res_data_next = '0;
          res_err_next  = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_next    = ST_IDLE;
          sum_next      = '0;
          prod_next     = WIDTH'(1);
          res_data_next = '0;
          res_err_next  = 1'b0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        sum_next      = '0;
        prod_next     = WIDTH'(1);
        res_data_next = '0;
        res_err_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg    <= ST_IDLE;
      sum_reg      <= '0;
      prod_reg     <= WIDTH'(1);
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sum_reg      <= sum_next;
      prod_reg     <= prod_next;
      res_data_reg <= res_data_next;
      res_err_reg  <= res_err_next;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Bench for expr_eval_ctrl: a 16-bit and an 8-bit instance share one stimulus
// stream so both widths are checked against hand-computed results.
module tb_expr_eval_ctrl;

  logic       clk;
  logic       clr_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       res_ready;

  int checks;
  int errors;

  expr_eval_ctrl_if #(.WIDTH(16)) b16 ();
  expr_eval_ctrl_if #(.WIDTH(8))  b8 ();

  assign b16.in_valid  = in_valid;
  assign b16.in_data   = in_data;
  assign b16.res_ready = res_ready;
  assign b8.in_valid   = in_valid;
  assign b8.in_data    = in_data;
  assign b8.res_ready  = res_ready;

  expr_eval_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .clr_n(clr_n), .bus(b16));
  expr_eval_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .clr_n(clr_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       s;
    logic [15:0] e16;
    logic [7:0]  e8;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge; the character is taken on the rising
  // edge in between, so in_ready sampled here predicts acceptance.
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!b16.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      send_char(s[i]);
    end
  endtask

  task automatic run_expr(input string s, input logic [15:0] e16, input logic [7:0] e8,
                          input logic err, input int max_gap);
    res_ready = 1'b1;
    send_str(s, max_gap);
    $display("expr \"%s\" -> res16=%0d res8=%0d err=%0d valid=%0d",
             s, b16.res_data, b8.res_data, b16.res_err, b16.res_valid);
    chk({s, " res_valid"}, 32'(b16.res_valid), 32'd1);
    chk({s, " res_data16"}, 32'(b16.res_data), 32'(e16));
    chk({s, " res_data8"}, 32'(b8.res_data), 32'(e8));
    chk({s, " res_err"}, 32'(b16.res_err), 32'(err));
    chk({s, " res_err8"}, 32'(b8.res_err), 32'(err));
    @(negedge clk);
    chk({s, " res_valid_after_hs"}, 32'(b16.res_valid), 32'd0);
    chk({s, " in_ready_after_hs"}, 32'(b16.in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b1;
    clr_n     = 1'b1;

    vecs[0]  = '{"1+2*3=",       16'd7,     8'd7,   1'b0};
    vecs[1]  = '{"9*9*9=",       16'd729,   8'd217, 1'b0};
    vecs[2]  = '{"9*9*9*9=",     16'd6561,  8'd161, 1'b0};
    vecs[3]  = '{"2+=",          16'd0,     8'd0,   1'b1};
    vecs[4]  = '{"1a+2=",        16'd0,     8'd0,   1'b1};
    vecs[5]  = '{"4=",           16'd4,     8'd4,   1'b0};
    vecs[6]  = '{"12=",          16'd0,     8'd0,   1'b1};
    vecs[7]  = '{"=",            16'd0,     8'd0,   1'b1};
    vecs[8]  = '{"8*0+6=",       16'd6,     8'd6,   1'b0};
    vecs[9]  = '{"9*9*9*9*9*9=", 16'd7153,  8'd241, 1'b0};
    vecs[10] = '{"9+9*9*9*9*9=", 16'd59058, 8'd178, 1'b0};
    vecs[11] = '{"+3=",          16'd0,     8'd0,   1'b1};
    vecs[12] = '{"7+8*2+1=",     16'd24,    8'd24,  1'b0};
    vecs[13] = '{"0=",           16'd0,     8'd0,   1'b0};

    #1 clr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset res_valid", 32'(b16.res_valid), 32'd0);
    chk("reset res_data", 32'(b16.res_data), 32'd0);
    chk("reset res_err", 32'(b16.res_err), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 32'(b16.in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_expr(vecs[i].s, vecs[i].e16, vecs[i].e8, vecs[i].err, 0);
    end

    // Result backpressure with the next expression's first character waiting.
    res_ready = 1'b0;
    send_str("3*4=", 0);
    in_valid = 1'b1;
    in_data  = "5";
    for (int c = 0; c < 5; c++) begin
      chk("bp res_valid", 32'(b16.res_valid), 32'd1);
      chk("bp res_data", 32'(b16.res_data), 32'd12);
      chk("bp in_ready", 32'(b16.in_ready), 32'd0);
      @(negedge clk);
    end
    $display("backpressure \"3*4=\" held res16=%0d", b16.res_data);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp released res_valid", 32'(b16.res_valid), 32'd0);
    chk("bp released in_ready", 32'(b16.in_ready), 32'd1);
    run_expr("5=", 16'd5, 8'd5, 1'b0, 0);

    // Idle bubbles between characters.
    run_expr("8*0+6=", 16'd6, 8'd6, 1'b0, 3);
    run_expr("2*3+4*5=", 16'd26, 8'd26, 1'b0, 4);

    // Asynchronous reset mid-expression: prod must return to 1.
    send_str("7*", 0);
    #2 clr_n = 1'b0;
    #1;
    chk("midexpr rst res_valid", 32'(b16.res_valid), 32'd0);
    chk("midexpr rst res_data", 32'(b16.res_data), 32'd0);
    chk("midexpr rst res_err", 32'(b16.res_err), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    $display("reset after \"7*\"");
    run_expr("2+3=", 16'd5, 8'd5, 1'b0, 0);

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    send_str("6=", 0);
    chk("middone res_valid before", 32'(b16.res_valid), 32'd1);
    chk("middone res_data before", 32'(b16.res_data), 32'd6);
    #2 clr_n = 1'b0;
    #1;
    chk("middone rst res_valid", 32'(b16.res_valid), 32'd0);
    chk("middone rst res_data", 32'(b16.res_data), 32'd0);
    chk("middone rst in_ready", 32'(b16.in_ready), 32'd1);
    @(negedge clk);
    clr_n = 1'b1;
    $display("reset during pending result of \"6=\"");
    run_expr("1+1=", 16'd2, 8'd2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
